approx_add8_characterizer: RTL and testbench
============================================

APPROX_ADD8_CHARACTERIZER -- requirements
Module: approx_add8_characterizer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: begin a sweep; honoured only in IDLE or DONE.
REQ-004 SHALL have port stall, input, 1 bit: freeze the operand sweep for this cycle.
REQ-005 SHALL have port op_a, output, 8 bits: registered operand A driven to the combinational 8-bit unsigned adder under test.
REQ-006 SHALL have port op_b, output, 8 bits: registered operand B driven to the adder under test.
REQ-007 SHALL have port dut_o, input, 9 bits: adder-under-test sum for the current op_a/op_b, combinational and same cycle.
REQ-008 SHALL have port busy, output, 1 bit: high in SWEEP and FLUSH.
REQ-009 SHALL have port done, output, 1 bit: high in DONE, held until start or rst.
REQ-010 SHALL have port err_cnt, output, 17 bits: number of vectors with dut_o != op_a+op_b.
REQ-011 SHALL have port sum_abs_err, output, 25 bits: sum of |dut_o - (op_a+op_b)| over all vectors.
REQ-012 SHALL have port max_err, output, 9 bits: worst-case absolute error.
REQ-013 SHALL have port sum_sq_err, output, 35 bits: sum of squared errors; present only with CHAR_MSE_EN.

Function
REQ-014 SHALL implement FSM states IDLE, SWEEP, FLUSH and DONE.
REQ-015 SHALL, on start high in IDLE or DONE, clear all accumulators, load idx=0 and enter SWEEP on the next edge.
REQ-016 SHALL ignore start while busy.
REQ-017 SHALL use a 16-bit index idx, with op_a=idx[15:8] and op_b=idx[7:0], covering all 65536 pairs in ascending order.
REQ-018 SHALL, in SWEEP with stall low, compute exact = op_a+op_b (9 bits, zero-extended) and abs error = |dut_o - exact| (9 bits, no wrap), register them with a valid bit in stage 1, then increment idx.
REQ-019 SHALL, in SWEEP with stall high, hold idx and load stage 1 valid=0; no sample is counted.
REQ-020 SHALL, in stage 2, add a valid stage-1 error to sum_abs_err, compare it into max_err, increment err_cnt if the error is nonzero, and (with CHAR_MSE_EN) add error squared to sum_sq_err.
REQ-021 SHALL go SWEEP->FLUSH after the sample at idx=0xFFFF is taken; idx does not wrap or continue.
REQ-022 SHALL spend exactly 2 cycles in FLUSH to drain stages 1 and 2, ignoring stall, then enter DONE.
REQ-023 SHALL produce a total latency, with no stalls, of 65538 cycles from entering SWEEP to done high; each stall cycle adds 1 cycle.
REQ-024 SHALL make result outputs valid only when done is high; intermediate values are visible but unspecified as final.
REQ-025 SHALL ensure accumulator widths never overflow: worst case is 511 x 65536 for the sum and 511^2 x 65536 for the squared sum.

Reset
REQ-026 SHALL, on rst high at an edge, give state=IDLE, idx=0, op_a=op_b=0, busy=0, done=0, stage valids=0, and err_cnt=sum_abs_err=max_err=sum_sq_err=0.
REQ-027 SHALL let rst override start and stall, and SHALL abort a sweep mid-operation with no partial done.

Configuration
REQ-028 SHALL, when CHAR_MSE_EN is defined, include the 9x9 squarer, the 35-bit sum_sq_err accumulator and port.
REQ-029 SHALL, when CHAR_MSE_EN is undefined, omit the port and all squaring logic; all other behaviour is identical.

Structure
REQ-030 SHALL place the FSM state enum, N_VEC=65536, and width constants ERR_W=9, CNT_W=17, SUM_W=25, SQ_W=35 in package approx_char_pkg.
REQ-031 SHALL implement stage 2 (accumulate, max, count, square) in sub-module approx_err_acc; FSM, index and stage 1 stay in the top module.

Verification
REQ-032 SHALL verify an exact DUT (dut_o=op_a+op_b), no stall -> done after 65538 cycles; err_cnt=0, sum_abs_err=0, max_err=0, sum_sq_err=0.
REQ-033 SHALL verify DUT forced to 0 -> err_cnt=65535, sum_abs_err=16711680, max_err=510.
REQ-034 SHALL verify DUT = exact with bit0 forced to 1 -> err_cnt=32768, sum_abs_err=32768, max_err=1, sum_sq_err=32768 (CHAR_MSE_EN).
REQ-035 SHALL verify the REQ-034 DUT with stall high every 3rd SWEEP cycle -> identical totals; done delayed by the exact number of stall cycles.
REQ-036 SHALL verify rst pulsed at SWEEP cycle 1000 -> IDLE with all outputs 0; a new start yields the REQ-032 results unchanged.
REQ-037 SHALL verify start pulsed during SWEEP -> ignored, sweep length unchanged; start in DONE -> outputs cleared, new sweep begins.

Source files
------------

// File: rtl/approx_char_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the 8-bit
// approximate-adder characterizer. Optional MSE support: CHAR_MSE_EN.
package approx_char_pkg;

   localparam int N_VEC = 65536;
   localparam int IDX_W = 16;
   localparam int ERR_W = 9;
   localparam int CNT_W = 17;
   localparam int SUM_W = 25;
   localparam int SQ_W  = 35;
   localparam int SQR_W = 2 * ERR_W;

   localparam logic [IDX_W-1:0] IDX_LAST = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } char_state_e;

   // Absolute difference of two unsigned 9-bit values, never wraps.
   function automatic logic [ERR_W-1:0] abs_diff(input logic [ERR_W-1:0] a,
                                                input logic [ERR_W-1:0] b);
      if (a >= b) begin
         abs_diff = a - b;
      end else begin
         abs_diff = b - a;
      end
   endfunction

`ifdef CHAR_MSE_EN
   // 9x9 unsigned squarer for the squared-error accumulator.
   function automatic logic [SQR_W-1:0] err_square(input logic [ERR_W-1:0] e);
      err_square = {9'd0, e} * {9'd0, e};
   endfunction
`endif

endpackage

// File: rtl/approx_err_acc.sv
// Second pipeline stage of the characterizer: accumulates absolute error,
// tracks the worst case, counts wrong vectors and (with CHAR_MSE_EN) sums
// squared errors. Cleared synchronously when a new sweep is accepted.
module approx_err_acc
   import approx_char_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             vld_i,
   input  logic [ERR_W-1:0] err_i,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [SUM_W-1:0] sum_abs_err_o,
`ifdef CHAR_MSE_EN
   output logic [SQ_W-1:0]  sum_sq_err_o,
`endif
   output logic [ERR_W-1:0] max_err_o
);

   logic [CNT_W-1:0] err_cnt_q;
   logic [SUM_W-1:0] sum_abs_q;
   logic [ERR_W-1:0] max_err_q;

   // Accumulate count, absolute-error sum and worst case for each valid sample.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         err_cnt_q <= '0;
         sum_abs_q <= '0;
         max_err_q <= '0;
      end else if (vld_i) begin
         sum_abs_q <= sum_abs_q + SUM_W'(err_i);
         if (err_i > max_err_q) begin
            max_err_q <= err_i;
         end
         if (err_i != 9'd0) begin
            err_cnt_q <= err_cnt_q + 17'd1;
         end
      end
   end

   assign err_cnt_o     = err_cnt_q;
   assign sum_abs_err_o = sum_abs_q;
   assign max_err_o     = max_err_q;

`ifdef CHAR_MSE_EN
   logic [SQR_W-1:0] sq_d;
   logic [SQ_W-1:0]  sum_sq_q;

   // Square the incoming error for the MSE accumulator.
   always_comb begin
      sq_d = err_square(err_i);
   end

   // Accumulate squared error for each valid sample.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         sum_sq_q <= '0;
      end else if (vld_i) begin
         sum_sq_q <= sum_sq_q + SQ_W'(sq_d);
      end
   end

   assign sum_sq_err_o = sum_sq_q;
`endif

endmodule

// File: rtl/approx_add8_characterizer.sv
// Exhaustive error characterizer for a combinational 8-bit unsigned adder.
// Sweeps all 65536 operand pairs, registers each error in stage 1 and
// accumulates statistics in approx_err_acc (stage 2).
// Optional squared-error port and logic: define CHAR_MSE_EN.
module approx_add8_characterizer
   import approx_char_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stall,
   output logic [7:0]       op_a,
   output logic [7:0]       op_b,
   input  logic [8:0]       dut_o,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_cnt,
   output logic [SUM_W-1:0] sum_abs_err,
`ifdef CHAR_MSE_EN
   output logic [SQ_W-1:0]  sum_sq_err,
`endif
   output logic [ERR_W-1:0] max_err
);

   char_state_e      state_q;
   logic [IDX_W-1:0] idx_q;
   logic             busy_q;
   logic             done_q;
   logic             flush_cnt_q;

   logic             s1_vld_q;
   logic [ERR_W-1:0] s1_err_q;

   logic             accept_d;
   logic             sample_d;
   logic [ERR_W-1:0] exact_d;
   logic [ERR_W-1:0] err_d;

   // Operands come straight from the index register, so they are registered.
   assign op_a = idx_q[15:8];
   assign op_b = idx_q[7:0];
   assign busy = busy_q;
   assign done = done_q;

   // Start qualification, sample enable and absolute error of the adder.
   always_comb begin
      accept_d = start && ((state_q == IDLE) || (state_q == DONE));
      sample_d = (state_q == SWEEP) && !stall;
      exact_d  = {1'b0, op_a} + {1'b0, op_b};
      err_d    = abs_diff(dut_o, exact_d);
   end

   // Sweep control FSM with index counter and registered busy/done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= 16'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         flush_cnt_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q <= SWEEP;
                  idx_q   <= 16'd0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            SWEEP: begin
               if (!stall) begin
                  if (idx_q == IDX_LAST) begin
                     state_q     <= FLUSH;
                     flush_cnt_q <= 1'b0;
                  end else begin
                     idx_q <= idx_q + 16'd1;
                  end
               end
            end
            FLUSH: begin
               // Two cycles: the first lets stage 2 absorb the last sample.
               if (flush_cnt_q) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  flush_cnt_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Stage 1: capture the error of the current vector with its valid bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_err_q <= 9'd0;
      end else begin
         s1_vld_q <= sample_d;
         if (sample_d) begin
            s1_err_q <= err_d;
         end
      end
   end

   approx_err_acc u_acc (
      .clk_i         (clk),
      .rst_i         (rst),
      .clr_i         (accept_d),
      .vld_i         (s1_vld_q),
      .err_i         (s1_err_q),
      .err_cnt_o     (err_cnt),
      .sum_abs_err_o (sum_abs_err),
`ifdef CHAR_MSE_EN
      .sum_sq_err_o  (sum_sq_err),
`endif
      .max_err_o     (max_err)
   );

endmodule

// File: tb/tb_approx_add8_characterizer.sv
// Self-checking bench for approx_add8_characterizer: short aborted sweeps from
// a table, then one full sweep against a non-trivial adder model with stalls.
module tb_approx_add8_characterizer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stall;
   logic [7:0]  op_a;
   logic [7:0]  op_b;
   logic [8:0]  dut_o;
   logic        busy;
   logic        done;
   logic [16:0] err_cnt;
   logic [24:0] sum_abs_err;
   logic [8:0]  max_err;
`ifdef CHAR_MSE_EN
   logic [34:0] sum_sq_err;
`endif

   logic        mixed_mode;
   logic [8:0]  exact_m;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int         n_cyc;
      int         stall_every;
      int         start_at;
      logic [7:0] exp_a;
      logic [7:0] exp_b;
   } seg_t;

   typedef struct {
      longint cnt;
      longint sum;
      longint mx;
      longint sq;
      longint lat;
   } res_t;

   res_t sb_q[$];
   seg_t segs[5];

   always #5 clk = ~clk;

   approx_add8_characterizer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stall       (stall),
      .op_a        (op_a),
      .op_b        (op_b),
      .dut_o       (dut_o),
      .busy        (busy),
      .done        (done),
      .err_cnt     (err_cnt),
      .sum_abs_err (sum_abs_err),
`ifdef CHAR_MSE_EN
      .sum_sq_err  (sum_sq_err),
`endif
      .max_err     (max_err)
   );

   // Adder under test: always 0, or exact on the diagonal and inverted elsewhere.
   always_comb begin
      exact_m = {1'b0, op_a} + {1'b0, op_b};
      if (mixed_mode) begin
         dut_o = (op_a == op_b) ? exact_m : ~exact_m;
      end else begin
         dut_o = 9'd0;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_op_a"}, 64'(op_a), 64'd0);
      check({tag, "_op_b"}, 64'(op_b), 64'd0);
      check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
      check({tag, "_sum_abs"}, 64'(sum_abs_err), 64'd0);
      check({tag, "_max_err"}, 64'(max_err), 64'd0);
`ifdef CHAR_MSE_EN
      check({tag, "_sum_sq"}, 64'(sum_sq_err), 64'd0);
`endif
   endtask

   // Reference statistics of the mixed adder over all 65536 pairs.
   function automatic res_t model_totals();
      res_t r;
      int   ex, d, e;
      r = '{cnt: 0, sum: 0, mx: 0, sq: 0, lat: 0};
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 256; b++) begin
            ex = a + b;
            d  = (a == b) ? ex : 511 - ex;
            e  = (d > ex) ? d - ex : ex - d;
            if (e != 0) r.cnt++;
            r.sum += e;
            if (e > r.mx) r.mx = e;
            r.sq += longint'(e) * longint'(e);
         end
      end
      return r;
   endfunction

   initial begin
      res_t exp_r;
      res_t got_exp;
      int   cyc;
      bit   done_flag;

      // n_cyc, stall_every, start_at, expected op_a/op_b when aborted
      segs[0] = '{1000, 0, 0,   8'd3, 8'd232};
      segs[1] = '{1000, 3, 0,   8'd2, 8'd155};
      segs[2] = '{600,  0, 300, 8'd2, 8'd88};
      segs[3] = '{1,    0, 0,   8'd0, 8'd1};
      segs[4] = '{300,  2, 0,   8'd0, 8'd150};

      rst = 1'b1; start = 1'b0; stall = 1'b0; mixed_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_cleared("reset");

      // Aborted sweeps: index progress, ignored start, no done, reset clears.
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         done_flag = 1'b0;
         for (int c = 1; c <= segs[i].n_cyc; c++) begin
            stall = (segs[i].stall_every != 0) && (c % segs[i].stall_every == 0);
            start = (c == segs[i].start_at);
            @(posedge clk); #1;
            if (done) done_flag = 1'b1;
         end
         stall = 1'b0; start = 1'b0;
         check($sformatf("seg%0d_op_a", i), 64'(op_a), 64'(segs[i].exp_a));
         check($sformatf("seg%0d_op_b", i), 64'(op_b), 64'(segs[i].exp_b));
         check($sformatf("seg%0d_busy", i), 64'(busy), 64'd1);
         check($sformatf("seg%0d_no_done", i), 64'(done_flag), 64'd0);
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         check_cleared($sformatf("seg%0d_abort", i));
      end

      // Full sweep with stalls on every 3rd of the first 300 sweep cycles.
      mixed_mode = 1'b1;
      exp_r = model_totals();
      exp_r.lat = 65538 + 100;
      sb_q.push_back(exp_r);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 70000) begin
         stall = ((cyc + 1) <= 300) && ((cyc + 1) % 3 == 0);
         @(posedge clk); #1;
         cyc++;
      end
      stall = 1'b0;
      check("sweep_done_reached", 64'(done), 64'd1);
      got_exp = sb_q.pop_front();
      check("sweep_latency", 64'(cyc), 64'(got_exp.lat));
      check("sweep_busy_low", 64'(busy), 64'd0);
      check("sweep_err_cnt", 64'(err_cnt), 64'(got_exp.cnt));
      check("sweep_sum_abs", 64'(sum_abs_err), 64'(got_exp.sum));
      check("sweep_max_err", 64'(max_err), 64'(got_exp.mx));
`ifdef CHAR_MSE_EN
      check("sweep_sum_sq", 64'(sum_sq_err), 64'(got_exp.sq));
`endif

      // Results and done hold while idle in DONE.
      repeat (5) @(posedge clk);
      #1;
      check("hold_done", 64'(done), 64'd1);
      check("hold_err_cnt", 64'(err_cnt), 64'(got_exp.cnt));
      check("hold_max_err", 64'(max_err), 64'(got_exp.mx));

      // Start from DONE clears results and begins a fresh sweep.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("restart_done", 64'(done), 64'd0);
      check("restart_busy", 64'(busy), 64'd1);
      check("restart_err_cnt", 64'(err_cnt), 64'd0);
      check("restart_sum_abs", 64'(sum_abs_err), 64'd0);
      check("restart_max_err", 64'(max_err), 64'd0);
      check("restart_op_a", 64'(op_a), 64'd0);
      check("restart_op_b", 64'(op_b), 64'd0);
      repeat (10) @(posedge clk);
      #1;
      check("restart_progress_op_b", 64'(op_b), 64'd10);

      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_cleared("final_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
